// File: rtl/nms_window_buf.sv
// nms_window_buf
//   Sliding WIN x WIN window over the FAST corner-score stream, used ahead of
//   the non-maximum-suppression comparator. WIN-1 line buffers hold the
//   previous rows. A shift register per window row holds the last WIN
//   columns. A window is emitted one accepted beat after every pixel whose
//   window lies fully inside the frame. Non-corner pixels enter as score 0.
//
//   Optional feature macro: NMS_CORNER_CNT_EN
//     When defined, adds frame_corner_cnt. This is the number of corner
//     pixels accepted in the frame that just completed. It is latched
//     together with frame_done.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ce                global enable; ce=0 freezes every register
//   in_vld            pixel beat valid
//   in_sof            with in_vld: pixel is (0,0)
//   in_eol            with in_vld: last pixel of the line
//   in_corner         pixel is a corner
//   in_score          corner score
//   win_score         window; tap (r,c) at [(r*WIN+c)*SCORE_W +: SCORE_W].
//                     r=0 is the oldest row; c=0 is the oldest column.
//   win_vld           window valid (one ce cycle per interior pixel)
//   ctr_x, ctr_y      frame coordinate of the window centre
//   frame_done        one-beat pulse after the last pixel of a frame
//   err_line          sticky line-length error, cleared by rst or accepted in_sof
//   frame_corner_cnt  (NMS_CORNER_CNT_EN only) corner count of the last frame
module nms_window_buf #(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int WIN     = 3,
    parameter int SCORE_W = 13,
    parameter int COORD_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_vld,
    input  logic                       in_sof,
    input  logic                       in_eol,
    input  logic                       in_corner,
    input  logic [SCORE_W-1:0]         in_score,
    output logic [WIN*WIN*SCORE_W-1:0] win_score,
    output logic                       win_vld,
    output logic [COORD_W-1:0]         ctr_x,
    output logic [COORD_W-1:0]         ctr_y,
    output logic                       frame_done,
    output logic                       err_line
`ifdef NMS_CORNER_CNT_EN
    ,
    output logic [2*COORD_W-1:0]       frame_corner_cnt
`endif
);

    localparam int H   = (WIN - 1) / 2;
    localparam int NLB = WIN - 1;
    localparam int AW  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COL_NUM - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUM - 1);
    localparam logic [COORD_W-1:0] EDGE   = COORD_W'(WIN - 1);
    localparam logic [COORD_W-1:0] HALF   = COORD_W'(H);

    // The stream is ignored after reset until a start-of-frame is accepted.
    typedef enum logic {ST_WAIT_SOF, ST_RUN} state_t;
    state_t state, state_nxt;

    logic [COORD_W-1:0]         col_cnt, row_cnt;
    logic [COORD_W-1:0]         x, y;
    logic [AW-1:0]              addr;
    logic [SCORE_W-1:0]         d;
    logic                       accept, proc, line_end, last_row, interior, len_err;

    logic [SCORE_W-1:0]         lb     [NLB][COL_NUM];
    logic [SCORE_W-1:0]         lb_rd  [NLB];
    logic [SCORE_W-1:0]         sr     [WIN][WIN];
    logic [SCORE_W-1:0]         sr_nxt [WIN][WIN];
    logic [WIN*WIN*SCORE_W-1:0] win_nxt;

    assign accept   = ce & in_vld;
    assign x        = in_sof ? '0 : col_cnt;
    assign y        = in_sof ? '0 : row_cnt;
    assign addr     = x[AW-1:0];
    assign d        = in_corner ? in_score : '0;
    assign line_end = in_eol | (x == X_LAST);
    assign last_row = (y == Y_LAST);
    assign interior = (x >= EDGE) && (y >= EDGE);
    // An eol away from the last column, or the last column without eol,
    // is a line-length error. Both cases still end the line.
    assign len_err  = in_eol ^ (x == X_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_WAIT_SOF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        proc      = 1'b0;
        case (state)
            ST_WAIT_SOF: begin
                if (accept && in_sof) begin
                    proc      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  proc = accept;
            default: state_nxt = ST_WAIT_SOF;
        endcase
    end

    // Read-before-write: lb[j] holds row y-1-j at column x.
    always_comb begin
        for (int j = 0; j < NLB; j++) lb_rd[j] = lb[j][addr];
    end

    // Each row register shifts one column toward c=0. The newest row takes
    // the incoming pixel. Older rows take the matching line-buffer outputs.
    always_comb begin
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN - 1; c++) sr_nxt[r][c] = sr[r][c+1];
        for (int r = 0; r < WIN - 1; r++) sr_nxt[r][WIN-1] = lb_rd[WIN-2-r];
        sr_nxt[WIN-1][WIN-1] = d;
    end

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                win_nxt[(r*WIN+c)*SCORE_W +: SCORE_W] = sr_nxt[r][c];
    end

    // Line-buffer RAM is never cleared. The row counter keeps stale rows
    // out of any emitted window.
    always_ff @(posedge clk) begin
        if (proc) begin
            lb[0][addr] <= d;
            for (int j = 1; j < NLB; j++) lb[j][addr] <= lb_rd[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_vld    <= 1'b0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            ctr_x      <= '0;
            ctr_y      <= '0;
            win_score  <= '0;
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++) sr[r][c] <= '0;
        end else if (ce) begin
            win_vld    <= proc & interior;
            frame_done <= proc & line_end & last_row;
            if (proc) begin
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++) sr[r][c] <= sr_nxt[r][c];
                err_line <= (err_line & ~in_sof) | len_err;
                if (line_end) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? '0 : y + COORD_W'(1);
                end else begin
                    col_cnt <= x + COORD_W'(1);
                    row_cnt <= y;
                end
                if (interior) begin
                    win_score <= win_nxt;
                    ctr_x     <= x - HALF;
                    ctr_y     <= y - HALF;
                end
            end
        end
    end

`ifdef NMS_CORNER_CNT_EN
    logic [2*COORD_W-1:0] corner_cnt, corner_sum;

    // An accepted sof restarts the count, including the sof pixel itself.
    assign corner_sum = (in_sof ? '0 : corner_cnt) + {{(2*COORD_W-1){1'b0}}, in_corner};

    always_ff @(posedge clk) begin
        if (rst) begin
            corner_cnt       <= '0;
            frame_corner_cnt <= '0;
        end else if (proc) begin
            if (line_end && last_row) begin
                frame_corner_cnt <= corner_sum;
                corner_cnt       <= '0;
            end else begin
                corner_cnt <= corner_sum;
            end
        end
    end
`endif

endmodule
